// File: rtl/mc65xx_rf_pkg.sv
// -----------------------------------------------------------------------------
// mc65xx_rf_pkg
//   Shared constants and types for the MC65xx register file.
//   - PSR bit indices in NV-BDIZC order. Bits 5/4 double as M/X in native mode.
//   - Reset constants for the PSR and the stack pointer.
//   - rf_mode_t: the effective E/M/X mode handed to the execution core.
//   - psr_view(): the PSR as seen by the outside world (bit 5 reads 1 in E mode).
// -----------------------------------------------------------------------------
package mc65xx_rf_pkg;

    localparam int PSR_C = 0;
    localparam int PSR_Z = 1;
    localparam int PSR_I = 2;
    localparam int PSR_D = 3;
    localparam int PSR_X = 4;   // index-width flag in native mode
    localparam int PSR_B = 4;   // break flag in emulation mode
    localparam int PSR_M = 5;   // accumulator-width flag in native mode
    localparam int PSR_V = 6;
    localparam int PSR_N = 7;

    localparam logic [7:0]  RESET_PSR_DEFAULT  = 8'h34;
    localparam logic [7:0]  STACK_PAGE_DEFAULT = 8'h01;
    localparam logic [15:0] S_RESET            = 16'h01FF;

    typedef struct packed {
        logic e;   // emulation mode
        logic m;   // 8-bit accumulator
        logic x;   // 8-bit index registers
    } rf_mode_t;

    // In emulation mode the unused bit 5 always reads as 1; bit 4 is B.
    function automatic logic [7:0] psr_view(input logic [7:0] psr, input logic e);
        logic [7:0] v;
        v = psr;
        if (e) v[PSR_M] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mc65xx_psr.sv
// -----------------------------------------------------------------------------
// mc65xx_psr
//   Processor status register plus the emulation flag E.
//   - Full load (PLP/RTI) takes priority over the per-bit masked flag writes.
//   - XCE swaps C and E; entering emulation forces the stored M/X bits to 1.
//   - Decodes the effective mode (E, 8-bit A, 8-bit index) and also exposes the
//     next-cycle E and X so the parent can act on mode changes on the same edge.
// Ports
//   clk, rst_x   clock, asynchronous active-low reset
//   i_set_psr    load PSR from i_psr
//   i_psr        PSR load value
//   i_flags      flag values (NV-BDIZC)
//   i_flag_we    per-bit write enables for i_flags
//   i_xce        exchange C and E (ignored when WIDE_EN=0)
//   o_psr        PSR as pushed
//   o_mode       effective E/M/X
//   o_e_next     E after the current edge
//   o_x_next     effective 8-bit-index flag after the current edge
// -----------------------------------------------------------------------------
module mc65xx_psr
    import mc65xx_rf_pkg::*;
#(
    parameter bit         WIDE_EN   = 1'b0,
    parameter logic [7:0] RESET_PSR = RESET_PSR_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_x,
    input  logic       i_set_psr,
    input  logic [7:0] i_psr,
    input  logic [7:0] i_flags,
    input  logic [7:0] i_flag_we,
    input  logic       i_xce,
    output logic [7:0] o_psr,
    output rf_mode_t   o_mode,
    output logic       o_e_next,
    output logic       o_x_next
);

    logic [7:0] r_psr;
    logic       r_e;
    logic [7:0] w_psr_next;
    logic       w_e_next;
    logic       w_xce;

    // A strict 6502 has no XCE; E stays at its reset value of 1.
    assign w_xce = WIDE_EN & i_xce;

    // NOTE: every signal assigned in always_comb gets a default on entry so
    // that no path leaves it unassigned and infers a latch.
    always_comb begin
        w_e_next = r_e;
        if (i_set_psr) begin
            w_psr_next = i_psr;
        end else begin
            w_psr_next = (r_psr & ~i_flag_we) | (i_flags & i_flag_we);
        end
        if (w_xce) begin
            w_e_next          = r_psr[PSR_C];
            w_psr_next[PSR_C] = r_e;
            // Native -> emulation: registers drop to 8 bits.
            if (r_psr[PSR_C] && !r_e) begin
                w_psr_next[PSR_M] = 1'b1;
                w_psr_next[PSR_X] = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            r_psr <= RESET_PSR;
            r_e   <= 1'b1;
        end else begin
            r_psr <= w_psr_next;
            r_e   <= w_e_next;
        end
    end

    assign o_psr    = psr_view(r_psr, r_e);
    assign o_mode.e = r_e;
    assign o_mode.m = !WIDE_EN || r_e || r_psr[PSR_M];
    assign o_mode.x = !WIDE_EN || r_e || r_psr[PSR_X];
    assign o_e_next = w_e_next;
    assign o_x_next = !WIDE_EN || w_e_next || w_psr_next[PSR_X];

endmodule

// File: rtl/mc65xx_register_file.sv
// -----------------------------------------------------------------------------
// mc65xx_register_file
//   Register file for the MC65xx core: PC, A, X, Y, S and PSR.
//   - PC: full load > byte-lane loads > fetch increment. The increment covers
//     PC[15:0] only; the bank byte (ADDR_W=24) never carries.
//   - S: direct write beats push/pull; net delta is pull - pushes (-2..+1).
//     In 8-bit stack mode the high byte is pinned to STACK_PAGE.
//   - A/X/Y: width follows the effective M/X mode (always 8-bit if WIDE_EN=0).
//   All outputs come straight from registers.
// Ports
//   clk, rst_x                       clock, asynchronous active-low reset
//   il2rf_data, il2rf_set_pc{l,h,b}  PC byte-lane loads
//   il2rf_pushed, mc2rf_pushed       S decrement requests
//   mc2rf_pull                       S increment request
//   mc2rf_fetched                    PC increment request
//   mc2rf_pc, mc2rf_set_pc           full PC load
//   mc2rf_psr, mc2rf_set_psr         full PSR load
//   ec2rf_data, ec2rf_set_{a,x,y,s}  register writes from the execution core
//   ec2rf_flags, ec2rf_flag_we       masked flag writes
//   ec2rf_xce                        exchange C and E
//   rf2mc_pc/_a/_x/_y/_s/_psr        register values
//   rf2ec_e/_m/_x                    effective mode
// -----------------------------------------------------------------------------
module mc65xx_register_file
    import mc65xx_rf_pkg::*;
#(
    parameter int         ADDR_W     = 16,
    parameter bit         WIDE_EN    = 1'b0,
    parameter logic [7:0] STACK_PAGE = STACK_PAGE_DEFAULT,
    parameter logic [7:0] RESET_PSR  = RESET_PSR_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_x,
    input  logic [7:0]        il2rf_data,
    input  logic              il2rf_set_pcl,
    input  logic              il2rf_set_pch,
    input  logic              il2rf_set_pcb,
    input  logic              il2rf_pushed,
    input  logic              mc2rf_fetched,
    input  logic              mc2rf_pushed,
    input  logic              mc2rf_pull,
    input  logic [ADDR_W-1:0] mc2rf_pc,
    input  logic              mc2rf_set_pc,
    input  logic [7:0]        mc2rf_psr,
    input  logic              mc2rf_set_psr,
    input  logic [15:0]       ec2rf_data,
    input  logic              ec2rf_set_a,
    input  logic              ec2rf_set_x,
    input  logic              ec2rf_set_y,
    input  logic              ec2rf_set_s,
    input  logic [7:0]        ec2rf_flags,
    input  logic [7:0]        ec2rf_flag_we,
    input  logic              ec2rf_xce,
    output logic [ADDR_W-1:0] rf2mc_pc,
    output logic [15:0]       rf2mc_a,
    output logic [15:0]       rf2mc_x,
    output logic [15:0]       rf2mc_y,
    output logic [15:0]       rf2mc_s,
    output logic [7:0]        rf2mc_psr,
    output logic              rf2ec_e,
    output logic              rf2ec_m,
    output logic              rf2ec_x
);

    localparam bit HAS_PCB = (ADDR_W > 16);

    // ---------------------------------------------------------------- PSR / E
    rf_mode_t w_mode;
    logic     w_e_next;
    logic     w_x_flag_next;

    mc65xx_psr #(
        .WIDE_EN   (WIDE_EN),
        .RESET_PSR (RESET_PSR)
    ) u_psr (
        .clk       (clk),
        .rst_x     (rst_x),
        .i_set_psr (mc2rf_set_psr),
        .i_psr     (mc2rf_psr),
        .i_flags   (ec2rf_flags),
        .i_flag_we (ec2rf_flag_we),
        .i_xce     (ec2rf_xce),
        .o_psr     (rf2mc_psr),
        .o_mode    (w_mode),
        .o_e_next  (w_e_next),
        .o_x_next  (w_x_flag_next)
    );

    assign rf2ec_e = w_mode.e;
    assign rf2ec_m = w_mode.m;
    assign rf2ec_x = w_mode.x;

    // ---------------------------------------------------------------- PC
    logic [15:0] r_pc_lo;
    logic [15:0] w_pc_lo_next;
    logic        w_lane_load;

    // A bank-lane load only counts when the bank byte exists.
    assign w_lane_load = il2rf_set_pcl | il2rf_set_pch | (HAS_PCB & il2rf_set_pcb);

    always_comb begin
        w_pc_lo_next = r_pc_lo;
        if (mc2rf_set_pc) begin
            w_pc_lo_next = mc2rf_pc[15:0];
        end else if (w_lane_load) begin
            if (il2rf_set_pcl) w_pc_lo_next[7:0]  = il2rf_data;
            if (il2rf_set_pch) w_pc_lo_next[15:8] = il2rf_data;
        end else if (mc2rf_fetched) begin
            w_pc_lo_next = r_pc_lo + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) r_pc_lo <= '0;
        else        r_pc_lo <= w_pc_lo_next;
    end

    generate
        if (HAS_PCB) begin : g_pcb
            logic [ADDR_W-17:0] r_pcb;
            logic [ADDR_W-17:0] w_pcb_next;

            always_comb begin
                w_pcb_next = r_pcb;
                if (mc2rf_set_pc)       w_pcb_next = mc2rf_pc[ADDR_W-1:16];
                else if (il2rf_set_pcb) w_pcb_next = il2rf_data[ADDR_W-17:0];
            end

            always_ff @(posedge clk or negedge rst_x) begin
                if (!rst_x) r_pcb <= '0;
                else        r_pcb <= w_pcb_next;
            end

            assign rf2mc_pc = {r_pcb, r_pc_lo};
        end else begin : g_no_pcb
            assign rf2mc_pc = r_pc_lo;
        end
    endgenerate

    // ---------------------------------------------------------------- S
    logic [15:0] r_s;
    logic [15:0] w_s_next;
    logic [15:0] w_s_delta;
    logic        w_page_now;
    logic        w_page_next;

    assign w_page_now  = !WIDE_EN || w_mode.e;
    assign w_page_next = !WIDE_EN || w_e_next;

    always_comb begin
        w_s_delta = {15'd0, mc2rf_pull} - {15'd0, mc2rf_pushed} - {15'd0, il2rf_pushed};
        if (ec2rf_set_s) begin
            w_s_next = w_page_now ? {8'h00, ec2rf_data[7:0]} : ec2rf_data;
        end else begin
            // The low byte of a 16-bit add equals the 8-bit page-wrapped result,
            // so pinning the high byte afterwards covers both stack modes.
            w_s_next = r_s + w_s_delta;
        end
        if (w_page_next) w_s_next[15:8] = STACK_PAGE;
    end

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) r_s <= S_RESET;
        else        r_s <= w_s_next;
    end

    assign rf2mc_s = w_page_now ? {STACK_PAGE, r_s[7:0]} : r_s;

    // ---------------------------------------------------------------- A / X / Y
    logic [15:0] r_a, r_x, r_y;
    logic [15:0] w_a_next, w_x_next, w_y_next;

    always_comb begin
        w_a_next = r_a;
        w_x_next = r_x;
        w_y_next = r_y;

        // 8-bit accumulator keeps the hidden high byte (B) intact.
        if (ec2rf_set_a) begin
            if (w_mode.m) w_a_next[7:0] = ec2rf_data[7:0];
            else          w_a_next      = ec2rf_data;
        end
        if (ec2rf_set_x) w_x_next = w_mode.x ? {8'h00, ec2rf_data[7:0]} : ec2rf_data;
        if (ec2rf_set_y) w_y_next = w_mode.x ? {8'h00, ec2rf_data[7:0]} : ec2rf_data;

        // Index high bytes are zero whenever the index width is 8 bits; this
        // also covers the X 0->1 transition and entry into emulation mode.
        if (w_x_flag_next) begin
            w_x_next[15:8] = 8'h00;
            w_y_next[15:8] = 8'h00;
        end
    end

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            r_a <= '0;
            r_x <= '0;
            r_y <= '0;
        end else begin
            r_a <= w_a_next;
            r_x <= w_x_next;
            r_y <= w_y_next;
        end
    end

    assign rf2mc_a = r_a;
    assign rf2mc_x = r_x;
    assign rf2mc_y = r_y;

endmodule

// File: tb/tb_mc65xx_register_file.sv
// -----------------------------------------------------------------------------
// tb_mc65xx_register_file
//   Directed bench for two configurations sharing one stimulus bus:
//   u_nar : ADDR_W=16, WIDE_EN=0 (strict 6502)
//   u_wid : ADDR_W=24, WIDE_EN=1 (65C816-style)
// -----------------------------------------------------------------------------
module tb_mc65xx_register_file;

    logic        clk = 1'b0;
    logic        rst_x;
    logic [7:0]  il2rf_data;
    logic        il2rf_set_pcl, il2rf_set_pch, il2rf_set_pcb, il2rf_pushed;
    logic        mc2rf_fetched, mc2rf_pushed, mc2rf_pull;
    logic [23:0] mc2rf_pc;
    logic        mc2rf_set_pc;
    logic [7:0]  mc2rf_psr;
    logic        mc2rf_set_psr;
    logic [15:0] ec2rf_data;
    logic        ec2rf_set_a, ec2rf_set_x, ec2rf_set_y, ec2rf_set_s;
    logic [7:0]  ec2rf_flags, ec2rf_flag_we;
    logic        ec2rf_xce;

    logic [15:0] n_pc, n_a, n_x, n_y, n_s;
    logic [7:0]  n_psr;
    logic        n_e, n_m, n_xf;
    logic [23:0] w_pc;
    logic [15:0] w_a, w_x, w_y, w_s;
    logic [7:0]  w_psr;
    logic        w_e, w_m, w_xf;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mc65xx_register_file #(.ADDR_W(16), .WIDE_EN(1'b0)) u_nar (
        .clk(clk), .rst_x(rst_x),
        .il2rf_data(il2rf_data), .il2rf_set_pcl(il2rf_set_pcl),
        .il2rf_set_pch(il2rf_set_pch), .il2rf_set_pcb(il2rf_set_pcb),
        .il2rf_pushed(il2rf_pushed), .mc2rf_fetched(mc2rf_fetched),
        .mc2rf_pushed(mc2rf_pushed), .mc2rf_pull(mc2rf_pull),
        .mc2rf_pc(mc2rf_pc[15:0]), .mc2rf_set_pc(mc2rf_set_pc),
        .mc2rf_psr(mc2rf_psr), .mc2rf_set_psr(mc2rf_set_psr),
        .ec2rf_data(ec2rf_data), .ec2rf_set_a(ec2rf_set_a),
        .ec2rf_set_x(ec2rf_set_x), .ec2rf_set_y(ec2rf_set_y),
        .ec2rf_set_s(ec2rf_set_s), .ec2rf_flags(ec2rf_flags),
        .ec2rf_flag_we(ec2rf_flag_we), .ec2rf_xce(ec2rf_xce),
        .rf2mc_pc(n_pc), .rf2mc_a(n_a), .rf2mc_x(n_x), .rf2mc_y(n_y),
        .rf2mc_s(n_s), .rf2mc_psr(n_psr),
        .rf2ec_e(n_e), .rf2ec_m(n_m), .rf2ec_x(n_xf)
    );

    mc65xx_register_file #(.ADDR_W(24), .WIDE_EN(1'b1)) u_wid (
        .clk(clk), .rst_x(rst_x),
        .il2rf_data(il2rf_data), .il2rf_set_pcl(il2rf_set_pcl),
        .il2rf_set_pch(il2rf_set_pch), .il2rf_set_pcb(il2rf_set_pcb),
        .il2rf_pushed(il2rf_pushed), .mc2rf_fetched(mc2rf_fetched),
        .mc2rf_pushed(mc2rf_pushed), .mc2rf_pull(mc2rf_pull),
        .mc2rf_pc(mc2rf_pc), .mc2rf_set_pc(mc2rf_set_pc),
        .mc2rf_psr(mc2rf_psr), .mc2rf_set_psr(mc2rf_set_psr),
        .ec2rf_data(ec2rf_data), .ec2rf_set_a(ec2rf_set_a),
        .ec2rf_set_x(ec2rf_set_x), .ec2rf_set_y(ec2rf_set_y),
        .ec2rf_set_s(ec2rf_set_s), .ec2rf_flags(ec2rf_flags),
        .ec2rf_flag_we(ec2rf_flag_we), .ec2rf_xce(ec2rf_xce),
        .rf2mc_pc(w_pc), .rf2mc_a(w_a), .rf2mc_x(w_x), .rf2mc_y(w_y),
        .rf2mc_s(w_s), .rf2mc_psr(w_psr),
        .rf2ec_e(w_e), .rf2ec_m(w_m), .rf2ec_x(w_xf)
    );

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        il2rf_set_pcl = 0; il2rf_set_pch = 0; il2rf_set_pcb = 0; il2rf_pushed = 0;
        mc2rf_fetched = 0; mc2rf_pushed = 0; mc2rf_pull = 0;
        mc2rf_set_pc  = 0; mc2rf_set_psr = 0;
        ec2rf_set_a = 0; ec2rf_set_x = 0; ec2rf_set_y = 0; ec2rf_set_s = 0;
        ec2rf_flag_we = 8'h00; ec2rf_xce = 0;
    endtask

    // Apply the current inputs on the next rising edge, then settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_x = 1'b0;
        il2rf_data = 8'h00; mc2rf_pc = 24'h0; mc2rf_psr = 8'h00;
        ec2rf_data = 16'h0; ec2rf_flags = 8'h00;
        clr();
        repeat (2) @(posedge clk);
        #1 rst_x = 1'b1;

        // ---- 1: asynchronous reset mid-run, observed before any clock edge
        mc2rf_fetched = 1; step(); step(); clr();
        check("pc_runs", n_pc, 24'h0002);
        @(negedge clk); rst_x = 1'b0; #1;
        check("rst_pc",    n_pc,  24'h0000);
        check("rst_s",     n_s,   24'h01FF);
        check("rst_psr",   n_psr, 24'h34);
        check("rst_e",     n_e,   1'b1);
        check("rst_a",     n_a,   24'h0);
        check("rst_w_pc",  w_pc,  24'h000000);
        check("rst_w_e",   w_e,   1'b1);
        check("rst_w_m",   w_m,   1'b1);
        check("rst_w_x",   w_xf,  1'b1);
        @(negedge clk); rst_x = 1'b1;

        // ---- 2: lane loads override a held fetch
        mc2rf_fetched = 1; il2rf_data = 8'hEF; il2rf_set_pcl = 1; step();
        check("pcl_load", n_pc, 24'h00EF);
        il2rf_set_pcl = 0; il2rf_data = 8'hBE; il2rf_set_pch = 1; step();
        check("pch_load", n_pc, 24'hBEEF);
        il2rf_set_pch = 0; step();
        check("pc_inc", n_pc, 24'hBEF0);
        clr(); il2rf_data = 8'hFF; il2rf_set_pcl = 1; il2rf_set_pch = 1; step();
        check("pc_both_lanes", n_pc, 24'hFFFF);
        clr(); mc2rf_fetched = 1; step(); clr();
        check("pc_wrap", n_pc, 24'h0000);

        // ---- 3: page-mode stack
        ec2rf_data = 16'h0000; ec2rf_set_s = 1; step(); clr();
        check("s_set_page", n_s, 24'h0100);
        mc2rf_pushed = 1; step(); clr();
        check("s_push_wrap", n_s, 24'h01FF);
        mc2rf_pull = 1; step(); clr();
        check("s_pull_wrap", n_s, 24'h0100);
        mc2rf_pushed = 1; mc2rf_pull = 1; step(); clr();
        check("s_push_pull", n_s, 24'h0100);
        mc2rf_pushed = 1; il2rf_pushed = 1; step(); clr();
        check("s_double_push", n_s, 24'h01FE);
        check("w_s_double_push", w_s, 24'h01FE);

        // 8-bit writes on the strict core ignore the high data byte
        ec2rf_data = 16'hABCD; ec2rf_set_a = 1; ec2rf_set_x = 1; step(); clr();
        check("nar_a_8bit", n_a, 24'h00CD);
        check("nar_x_8bit", n_x, 24'h00CD);
        check("w_emu_a_8bit", w_a, 24'h00CD);

        // masked flag writes
        ec2rf_flags = 8'hFF; ec2rf_flag_we = 8'h03; step(); clr();
        check("flag_mask_nar", n_psr, 24'h37);
        check("flag_mask_wid", w_psr, 24'h37);
        ec2rf_flags = 8'h00; ec2rf_flag_we = 8'h03; step(); clr();
        check("flag_clear", n_psr, 24'h34);

        // ---- 5: xce into native mode (strict core ignores it)
        ec2rf_xce = 1; step(); clr();
        check("xce_nar_e",   n_e,   1'b1);
        check("xce_nar_psr", n_psr, 24'h34);
        check("xce_w_e",     w_e,   1'b0);
        check("xce_w_psr",   w_psr, 24'h35);
        check("xce_w_s",     w_s,   24'h01FE);

        // ---- 4: 24-bit PC
        mc2rf_pc = 24'h12FFFF; mc2rf_set_pc = 1; step(); clr();
        check("pc24_load", w_pc, 24'h12FFFF);
        mc2rf_fetched = 1; step(); clr();
        check("pc24_nocarry", w_pc, 24'h120000);
        mc2rf_pc = 24'h345678; mc2rf_set_pc = 1; mc2rf_fetched = 1; step(); clr();
        check("pc24_setpc_beats_fetch", w_pc, 24'h345678);
        il2rf_data = 8'h9A; il2rf_set_pcb = 1; mc2rf_fetched = 1; step(); clr();
        check("pcb_lane", w_pc, 24'h9A5678);

        // ---- 5 continued: accumulator width
        ec2rf_flags = 8'h00; ec2rf_flag_we = 8'h20; step(); clr();
        check("clr_m_flag", w_m, 1'b0);
        check("clr_m_psr",  w_psr, 24'h15);
        ec2rf_data = 16'h1234; ec2rf_set_a = 1; step(); clr();
        check("a16_write", w_a, 24'h1234);
        ec2rf_flags = 8'h20; ec2rf_flag_we = 8'h20; step(); clr();
        check("set_m_flag", w_m, 1'b1);
        ec2rf_data = 16'h00AB; ec2rf_set_a = 1; step(); clr();
        check("a8_keeps_high", w_a, 24'h12AB);

        // ---- 5b: index width and the X 0->1 transition
        ec2rf_flags = 8'h00; ec2rf_flag_we = 8'h10; step(); clr();
        check("clr_x_flag", w_xf, 1'b0);
        ec2rf_data = 16'h5678; ec2rf_set_x = 1; ec2rf_set_y = 1; step(); clr();
        check("x16_write", w_x, 24'h5678);
        check("y16_write", w_y, 24'h5678);
        ec2rf_flags = 8'h10; ec2rf_flag_we = 8'h10; step(); clr();
        check("x_rise_clears_x", w_x, 24'h0078);
        check("x_rise_clears_y", w_y, 24'h0078);

        // native 16-bit stack
        ec2rf_data = 16'h0000; ec2rf_set_s = 1; step(); clr();
        check("ns_set", w_s, 24'h0000);
        mc2rf_pushed = 1; step(); clr();
        check("ns_push_wrap", w_s, 24'hFFFF);
        mc2rf_pull = 1; step(); clr();
        check("ns_pull_wrap", w_s, 24'h0000);
        ec2rf_data = 16'h1234; ec2rf_set_s = 1; step(); clr();
        check("ns_set16", w_s, 24'h1234);

        // back into emulation with M=X=0 and a wide X
        ec2rf_flags = 8'h00; ec2rf_flag_we = 8'h30; step(); clr();
        check("mx_clear_psr", w_psr, 24'h05);
        ec2rf_data = 16'hABCD; ec2rf_set_x = 1; step(); clr();
        check("x16_abcd", w_x, 24'hABCD);
        ec2rf_xce = 1; step(); clr();
        check("emu_e",   w_e,   1'b1);
        check("emu_m",   w_m,   1'b1);
        check("emu_x",   w_xf,  1'b1);
        check("emu_s",   w_s,   24'h0134);
        check("emu_xhi", w_x,   24'h00CD);
        check("emu_psr", w_psr, 24'h34);

        // ---- 6: flag masking vs full PSR load (native mode)
        ec2rf_xce = 1; step(); clr();
        check("native_again_psr", w_psr, 24'h35);
        ec2rf_flags = 8'h00; ec2rf_flag_we = 8'h01; step(); clr();
        check("t6_start", w_psr, 24'h34);
        ec2rf_flags = 8'hFF; ec2rf_flag_we = 8'h03; step(); clr();
        check("t6_mask", w_psr, 24'h37);
        ec2rf_flags = 8'hFF; ec2rf_flag_we = 8'hFF;
        mc2rf_psr = 8'h80; mc2rf_set_psr = 1; step(); clr();
        check("t6_setpsr_wins", w_psr, 24'h80);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
